// File: rtl/fifo_ctrl.sv
// Control stage of an 8-entry FIFO: head/tail pointers, occupancy count,
// gated write/read strobes and registered per-request ack/error status.
module fifo_ctrl #(
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic          rd_en,
  output logic          we,
  output logic [AW-1:0] wr_addr,
  output logic          re,
  output logic [AW-1:0] rd_addr,
  output logic [AW:0]   data_count,
  output logic          full,
  output logic          empty,
  output logic          wr_ack,
  output logic          wr_err,
  output logic          rd_ack,
  output logic          rd_err,
  output logic [2:0]    state
);

  typedef enum logic [2:0] {
    INIT     = 3'b000,
    NO_OP    = 3'b001,
    WRITE    = 3'b010,
    WR_ERROR = 3'b011,
    READ     = 3'b100,
    RD_ERROR = 3'b101
  } state_t;

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  state_t        state_q;
  state_t        state_d;
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [AW:0]   count;

  // full/empty come from the count only; pointer equality is ambiguous
  assign full  = (count == DEPTH);
  assign empty = (count == '0);

  assign we = wr_en & ~rd_en & ~full  & ~reset;
  assign re = rd_en & ~wr_en & ~empty & ~reset;

  always_comb begin
    state_d = NO_OP;
    case (state_q)
      INIT, NO_OP, WRITE, WR_ERROR, READ, RD_ERROR: begin
        if (wr_en && !rd_en)      state_d = full  ? WR_ERROR : WRITE;
        else if (rd_en && !wr_en) state_d = empty ? RD_ERROR : READ;
      end
      default: state_d = NO_OP;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= INIT;
      head    <= '0;
      tail    <= '0;
      count   <= '0;
    end else begin
      state_q <= state_d;
      if (we) tail <= tail + 1'b1;
      if (re) head <= head + 1'b1;
      // we and re are mutually exclusive, so at most one adjustment applies
      if (we)      count <= count + 1'b1;
      else if (re) count <= count - 1'b1;
    end
  end

  assign wr_addr    = tail;
  assign rd_addr    = head;
  assign data_count = count;
  assign state      = state_q;

  assign wr_ack = (state_q == WRITE);
  assign wr_err = (state_q == WR_ERROR);
  assign rd_ack = (state_q == READ);
  assign rd_err = (state_q == RD_ERROR);

endmodule

// File: doc/fifo_ctrl.md
# fifo_ctrl

Control stage of the 8-entry FIFO. It sits directly upstream of the write-address decoder and the read multiplexer, and owns the FIFO bookkeeping:
- tracks the head and tail pointers, the data count and the operation state;
- turns raw `wr_en`/`rd_en` requests into a gated write enable plus write address (`we`, `wr_addr`) for the decoder, and a gated read strobe plus read address (`re`, `rd_addr`) for the read path;
- reports acknowledge and error status for each request.

It holds no data storage itself.

## Interface
Parameters:
- `AW`, default 3: pointer width. Depth is 2**AW, so 8 entries.

Ports:
- `clk`, input, 1: single clock; all state updates on its rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `wr_en`, input, 1: write request for this cycle.
- `rd_en`, input, 1: read request for this cycle.
- `we`, output, 1: gated write enable to the write-address decoder.
- `wr_addr`, output, AW: write address, equal to the tail pointer.
- `re`, output, 1: gated read strobe to the read path.
- `rd_addr`, output, AW: read address, equal to the head pointer.
- `data_count`, output, AW+1: number of valid entries, 0..8.
- `full`, output, 1: `data_count` == 8.
- `empty`, output, 1: `data_count` == 0.
- `wr_ack`, output, 1: previous cycle's write was accepted.
- `wr_err`, output, 1: previous cycle's write was rejected because the FIFO was full.
- `rd_ack`, output, 1: previous cycle's read was accepted.
- `rd_err`, output, 1: previous cycle's read was rejected because the FIFO was empty.
- `state`, output, 3: current state, for debug and verification.

## Operation
- **States and encoding:** INIT=000, NO_OP=001, WRITE=010, WR_ERROR=011, READ=100, RD_ERROR=101. Codes 110 and 111 are illegal and must recover to NO_OP on the next edge.
- **Next state, evaluated every cycle from the inputs and the registered count:**
  - `wr_en` & ~`rd_en` & ~`full` -> WRITE
  - `wr_en` & ~`rd_en` & `full` -> WR_ERROR
  - `rd_en` & ~`wr_en` & ~`empty` -> READ
  - `rd_en` & ~`wr_en` & `empty` -> RD_ERROR
  - both requests high, or both low -> NO_OP
- **Transition rules:** there is no direct path back to INIT except through `reset`. INIT is left on the first clock edge after reset deasserts, following the rules above.
- **Write gating:** `we` = `wr_en` & ~`rd_en` & ~`full`. On the edge where `we`=1:
  - the entry at `wr_addr` is written by the downstream decoder and register file;
  - the tail increments modulo 8;
  - `data_count` increments by 1.
- **Read gating:** `re` = `rd_en` & ~`wr_en` & ~`empty`. On the edge where `re`=1:
  - the head increments modulo 8;
  - `data_count` decrements by 1.
- **Pointer wrap-around:** 7 -> 0, with no special handling. `full` and `empty` are decoded only from `data_count`, never from pointer equality.
- **Status outputs:** decoded from the registered state, so they are registered outputs:
  - `wr_ack` = (state==WRITE)
  - `wr_err` = (state==WR_ERROR)
  - `rd_ack` = (state==READ)
  - `rd_err` = (state==RD_ERROR)
  - All four are 0 in INIT and NO_OP.
- **Rejected or no-op cycles:** a rejected write, a rejected read, a NO_OP or a simultaneous request leaves the pointers and the count unchanged.
- **Arithmetic:** `data_count` never exceeds 8 and never goes below 0. Gating guarantees this, and no saturation logic beyond the gating is permitted.

## Timing
- **Reset values (asynchronous, immediate on `reset`=1):**
  - state=INIT; head=0, tail=0, `data_count`=0.
  - `empty`=1, `full`=0.
  - `wr_ack`, `wr_err`, `rd_ack`, `rd_err` = 0.
  - `we`=0 and `re`=0 while `reset` is high, regardless of the request inputs.
- **Combinational outputs:** `we`, `re`, `wr_addr` and `rd_addr` are valid in the same cycle as the request. The memory write and the pointer update happen on the next rising edge.
- **Status latency:** status lags its request by exactly 1 cycle; a request at cycle N shows its ack/err during cycle N+1.
- **`full`/`empty` update:** both update on the same edge as `data_count`, so a write accepted at cycle N makes `empty`=0 in cycle N+1.
- **Back-to-back requests:** consecutive writes or reads, one per cycle, run at full rate with no bubbles.
- **Reset mid-operation:** clears pointers, count and status immediately. Stored data is not cleared but is unreachable, because the count is 0.
- **Combinational paths:** none from `wr_en`/`rd_en` to any registered output. The only such path is to `we`/`re`.

## Test plan
- **Reset and empty read:** assert `reset`, release, then `rd_en`=1 for 1 cycle. Required: `empty`=1 and `re`=0 that cycle; next cycle state=101, `rd_err`=1, `rd_ack`=0, `data_count`=0.
- **Fill and overflow:** 9 consecutive `wr_en` cycles.
  - Cycles 1–8: `we`=1, `wr_addr` = 0..7, `wr_ack`=1 the following cycle.
  - After the 8th write: `full`=1, `data_count`=8.
  - 9th cycle: `we`=0; next cycle `wr_err`=1 and tail stays 0.
- **Drain and wrap:** from full, 8 reads. Required: `rd_addr` = 0..7; `empty`=1 after the 8th read; head back to 0. Then 3 writes, 3 reads: `wr_addr` and `rd_addr` both 0,1,2.
- **Wrap-around mid-buffer:** 5 writes, 5 reads, then 6 writes. Required: `wr_addr` sequence 5,6,7,0,1,2; `data_count`=6; head=5.
- **Simultaneous requests:** with `data_count`=3, assert `wr_en`=`rd_en`=1. Required: `we`=`re`=0; next cycle state=001, all four status outputs 0, count still 3.
- **Asynchronous reset mid-stream:** with `data_count`=5, pulse `reset` between clock edges. Required: immediately state=000, `data_count`=0, `empty`=1, head=tail=0, status outputs 0, without waiting for `clk`.
